multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Finite-state sequencer for the multicycle RV32I core. It steps each instruction through fetch, decode, execute, memory and writeback. It drives the shared memory port handshake, IR/PC/register-file write enables and the datapath mux selects. It classifies instr[6:0] with the same opcode set the immediate generator decodes, so the sign-extended immediate is valid from DECODE onward.

## Interface
- TIMEOUT_CYCLES, 255: maximum wait cycles on a memory request before a timeout fault; range 1..65535.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- instr  in  32  IR contents, stable from DECODE until the next ir_we.
- branch_taken  in  1  ALU compare result for the current branch, valid in EXEC.
- mem_ready  in  1  memory accepts or completes the current request this cycle.
- mem_req  out  1  memory request.
- mem_we  out  1  store when 1, read when 0.
- mem_addr_sel  out  1  0 = PC (fetch), 1 = ALU result (data).
- ir_we  out  1  load IR and old_pc.
- pc_we  out  1  update PC.
- pc_src  out  2  0 = old_pc+4, 1 = old_pc+imm, 2 = ALU result with bit 0 cleared.
- reg_we  out  1  register-file write.
- wb_sel  out  2  0 = ALU, 1 = memory data, 2 = old_pc+4, 3 = imm.
- alu_a_sel  out  1  0 = rs1, 1 = old_pc.
- alu_b_sel  out  1  0 = rs2, 1 = imm.
- alu_op  out  2  0 = add, 1 = R-type funct, 2 = I-type funct, 3 = branch compare.
- instret  out  1  one-cycle pulse when an instruction retires.
- fault_code  out  2  0 = none, 1 = illegal opcode, 2 = memory timeout, 3 = ECALL/EBREAK.
- state_dbg  out  3  current state encoding.

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, FAULT=5. Encodings 6 and 7 go to FAULT with code 1.
- FETCH
  - Drives mem_req=1, mem_we=0, mem_addr_sel=0.
  - When mem_ready=1: ir_we=1 in the same cycle, then go to DECODE.
- DECODE
  - The classifier maps the opcode to one of: OP, OP-IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, FENCE, SYSTEM, ILLEGAL.
  - ILLEGAL goes to FAULT with code 1. SYSTEM goes to FAULT with code 3. All other classes go to EXEC.
- EXEC
  - OP: alu_a_sel=0, alu_b_sel=0, alu_op=1, then WB.
  - OP-IMM: alu_b_sel=1, alu_op=2, then WB.
  - LOAD/STORE: alu_b_sel=1, alu_op=0, then MEM.
  - BRANCH: alu_op=3, pc_we=1, pc_src = branch_taken ? 1 : 0, instret=1, then FETCH.
  - JAL: pc_we=1, pc_src=1, then WB.
  - JALR: alu_b_sel=1, alu_op=0, pc_we=1, pc_src=2, then WB.
  - AUIPC: alu_a_sel=1, alu_b_sel=1, alu_op=0, then WB.
  - LUI: then WB.
  - FENCE: pc_we=1, pc_src=0, instret=1, then FETCH (treated as a NOP).
- MEM
  - Drives mem_req=1, mem_addr_sel=1, mem_we=1 for STORE.
  - On mem_ready, LOAD goes to WB.
  - On mem_ready, STORE asserts pc_we=1, pc_src=0, instret=1, then goes to FETCH.
- WB
  - Asserts reg_we=1 and instret=1.
  - wb_sel: 1 for LOAD, 2 for JAL/JALR, 3 for LUI, 0 otherwise.
  - Asserts pc_we=1 with pc_src=0, except for JAL/JALR, where the PC was already written in EXEC.
  - Then goes to FETCH.
- FAULT
  - Sticky: all enables 0, mem_req=0, fault_code held. Only rst exits FAULT.
- Timeout
  - A 16-bit wait counter clears on entry to FETCH or MEM and increments each cycle mem_req=1 while mem_ready=0.
  - When the count equals TIMEOUT_CYCLES with mem_ready still 0, the next state is FAULT with code 2.
  - mem_ready=1 on that same cycle wins and the transfer completes.
- rd=x0 writes are suppressed by the register file, not by this block.

## Timing
- All outputs are decoded combinationally from the registered state, class register and mem_ready. No output has a register stage.
- While rst=1, all outputs are forced to 0, including mem_req.
- On the first edge with rst=1: state goes to FETCH, fault_code to 0, counter to 0, class register to ILLEGAL.
- mem_ready may rise in the first cycle of mem_req. Zero-wait cycle counts are:
  - BRANCH, FENCE: 3 cycles.
  - OP, OP-IMM, LUI, AUIPC, JAL, JALR, STORE: 4 cycles.
  - LOAD: 5 cycles.
- Each wait cycle on mem_ready adds one cycle.
- The class register latches in DECODE and holds through EXEC, MEM and WB.
- instret coincides with the final pc_we of each instruction; for JAL/JALR it pulses in WB. It never pulses in FAULT.
- Reset during MEM abandons the transfer: mem_req=0 in the reset cycle, and no pc_we or reg_we occurs.

## Structure
- Package rv_ctrl_pkg holds:
  - state encodings and opcode constants (0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111, 0001111, 1110011);
  - class encodings, pc_src/wb_sel/alu_op codes and fault codes.
- Sub-module opcode_classifier: combinational, instr[6:0] in, 4-bit class out. It is shared with the decode assertions in the bench.

## Test plan
- addi x1,x0,5 (0x00500093), mem_ready tied 1 -> states 0,1,2,4,0; alu_b_sel=1 and alu_op=2 in EXEC; reg_we, wb_sel=0, pc_we, instret in cycle 4.
- lw x2,0(x0) (0x00002103) with data mem_ready delayed 3 cycles -> MEM held 4 cycles with mem_we=0, mem_addr_sel=1; WB wb_sel=1; total 8 cycles.
- beq x0,x0,+8 (0x00000463), branch_taken=1 -> pc_we with pc_src=1 in cycle 3, no reg_we; repeat with branch_taken=0 -> pc_src=0.
- jal x1,+16 (0x010000EF) -> EXEC pc_we, pc_src=1; WB reg_we, wb_sel=2, instret, no pc_we.
- Opcode 0x7F -> FAULT, fault_code=1, mem_req=0 indefinitely; ecall (0x00000073) -> fault_code=3.
- TIMEOUT_CYCLES=4, fetch with mem_ready held 0 -> FAULT code 2 after 5 FETCH cycles; a separate run asserts rst during MEM of sw 0x00202223 -> no pc_we, FETCH next cycle, fault_code=0.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control sequencer: states, opcode classes,
// datapath select codes and fault codes.
package rv_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_FAULT  = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        CL_OP      = 4'd0,
        CL_OPIMM   = 4'd1,
        CL_LOAD    = 4'd2,
        CL_STORE   = 4'd3,
        CL_BRANCH  = 4'd4,
        CL_JAL     = 4'd5,
        CL_JALR    = 4'd6,
        CL_LUI     = 4'd7,
        CL_AUIPC   = 4'd8,
        CL_FENCE   = 4'd9,
        CL_SYSTEM  = 4'd10,
        CL_ILLEGAL = 4'd11
    } class_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [1:0] PC_SRC_SEQ = 2'd0;
    localparam logic [1:0] PC_SRC_REL = 2'd1;
    localparam logic [1:0] PC_SRC_ALU = 2'd2;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_MEM  = 2'd1;
    localparam logic [1:0] WB_LINK = 2'd2;
    localparam logic [1:0] WB_IMM  = 2'd3;

    localparam logic [1:0] ALU_ADD    = 2'd0;
    localparam logic [1:0] ALU_RTYPE  = 2'd1;
    localparam logic [1:0] ALU_ITYPE  = 2'd2;
    localparam logic [1:0] ALU_BRANCH = 2'd3;

    localparam logic [1:0] FAULT_NONE    = 2'd0;
    localparam logic [1:0] FAULT_ILLEGAL = 2'd1;
    localparam logic [1:0] FAULT_TIMEOUT = 2'd2;
    localparam logic [1:0] FAULT_SYSTEM  = 2'd3;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       mem_addr_sel;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       reg_we;
        logic [1:0] wb_sel;
        logic       alu_a_sel;
        logic       alu_b_sel;
        logic [1:0] alu_op;
        logic       instret;
    } ctrl_t;

    // JAL/JALR write the PC in EXEC and write the link address in WB.
    function automatic logic is_link(input class_e c);
        return (c == CL_JAL) || (c == CL_JALR);
    endfunction

endpackage

// File: rtl/multicycle_controller_classifier.sv
// Combinational opcode classifier; uses the same opcode set as the immediate generator.
module opcode_classifier
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    output class_e     class_o
);

    always_comb begin
        class_o = CL_ILLEGAL;
        case (opcode_i)
            OPC_OP:     class_o = CL_OP;
            OPC_OPIMM:  class_o = CL_OPIMM;
            OPC_LOAD:   class_o = CL_LOAD;
            OPC_STORE:  class_o = CL_STORE;
            OPC_BRANCH: class_o = CL_BRANCH;
            OPC_JAL:    class_o = CL_JAL;
            OPC_JALR:   class_o = CL_JALR;
            OPC_LUI:    class_o = CL_LUI;
            OPC_AUIPC:  class_o = CL_AUIPC;
            OPC_FENCE:  class_o = CL_FENCE;
            OPC_SYSTEM: class_o = CL_SYSTEM;
            default:    class_o = CL_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB with a sticky FAULT state.
// All outputs are combinational from the registered state, class register and mem_ready.
module multicycle_controller
    import rv_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        branch_taken,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic        alu_a_sel,
    output logic        alu_b_sel,
    output logic [1:0]  alu_op,
    output logic        instret,
    output logic [1:0]  fault_code,
    output logic [2:0]  state_dbg
);

    localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT_CYCLES);

    state_e      state_q, state_d;
    class_e      class_q, class_d;
    logic [1:0]  fault_q, fault_d;
    logic [15:0] wait_q, wait_d;
    class_e      cls_dec;
    ctrl_t       ctrl;
    ctrl_t       ctrl_out;
    logic        unused_instr;

    assign unused_instr = ^instr[31:7];

    opcode_classifier u_classifier (
        .opcode_i (instr[6:0]),
        .class_o  (cls_dec)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            class_q <= CL_ILLEGAL;
            fault_q <= FAULT_NONE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
            fault_q <= fault_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        class_d = class_q;
        fault_d = fault_q;
        wait_d  = wait_q;
        ctrl    = '0;

        case (state_q)
            ST_FETCH: begin
                ctrl.mem_req = 1'b1;
                if (mem_ready) begin
                    ctrl.ir_we = 1'b1;
                    state_d    = ST_DECODE;
                end else if (wait_q == TIMEOUT_W) begin
                    state_d = ST_FAULT;
                    fault_d = FAULT_TIMEOUT;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end

            ST_DECODE: begin
                class_d = cls_dec;
                case (cls_dec)
                    CL_ILLEGAL: begin
                        state_d = ST_FAULT;
                        fault_d = FAULT_ILLEGAL;
                    end
                    CL_SYSTEM: begin
                        state_d = ST_FAULT;
                        fault_d = FAULT_SYSTEM;
                    end
                    default: state_d = ST_EXEC;
                endcase
            end

            ST_EXEC: begin
                case (class_q)
                    CL_OP: begin
                        ctrl.alu_op = ALU_RTYPE;
                        state_d     = ST_WB;
                    end
                    CL_OPIMM: begin
                        ctrl.alu_b_sel = 1'b1;
                        ctrl.alu_op    = ALU_ITYPE;
                        state_d        = ST_WB;
                    end
                    CL_LOAD, CL_STORE: begin
                        ctrl.alu_b_sel = 1'b1;
                        ctrl.alu_op    = ALU_ADD;
                        state_d        = ST_MEM;
                    end
                    CL_BRANCH: begin
                        ctrl.alu_op  = ALU_BRANCH;
                        ctrl.pc_we   = 1'b1;
                        ctrl.pc_src  = branch_taken ? PC_SRC_REL : PC_SRC_SEQ;
                        ctrl.instret = 1'b1;
                        state_d      = ST_FETCH;
                    end
                    CL_JAL: begin
                        ctrl.pc_we  = 1'b1;
                        ctrl.pc_src = PC_SRC_REL;
                        state_d     = ST_WB;
                    end
                    CL_JALR: begin
                        ctrl.alu_b_sel = 1'b1;
                        ctrl.alu_op    = ALU_ADD;
                        ctrl.pc_we     = 1'b1;
                        ctrl.pc_src    = PC_SRC_ALU;
                        state_d        = ST_WB;
                    end
                    CL_AUIPC: begin
                        ctrl.alu_a_sel = 1'b1;
                        ctrl.alu_b_sel = 1'b1;
                        ctrl.alu_op    = ALU_ADD;
                        state_d        = ST_WB;
                    end
                    CL_LUI: state_d = ST_WB;
                    CL_FENCE: begin
                        ctrl.pc_we   = 1'b1;
                        ctrl.pc_src  = PC_SRC_SEQ;
                        ctrl.instret = 1'b1;
                        state_d      = ST_FETCH;
                    end
                    default: begin
                        state_d = ST_FAULT;
                        fault_d = FAULT_ILLEGAL;
                    end
                endcase
            end

            ST_MEM: begin
                ctrl.mem_req      = 1'b1;
                ctrl.mem_addr_sel = 1'b1;
                ctrl.mem_we       = (class_q == CL_STORE);
                if (mem_ready) begin
                    if (class_q == CL_STORE) begin
                        ctrl.pc_we   = 1'b1;
                        ctrl.pc_src  = PC_SRC_SEQ;
                        ctrl.instret = 1'b1;
                        state_d      = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (wait_q == TIMEOUT_W) begin
                    state_d = ST_FAULT;
                    fault_d = FAULT_TIMEOUT;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end

            ST_WB: begin
                ctrl.reg_we  = 1'b1;
                ctrl.instret = 1'b1;
                case (class_q)
                    CL_LOAD:         ctrl.wb_sel = WB_MEM;
                    CL_JAL, CL_JALR: ctrl.wb_sel = WB_LINK;
                    CL_LUI:          ctrl.wb_sel = WB_IMM;
                    default:         ctrl.wb_sel = WB_ALU;
                endcase
                ctrl.pc_we  = !is_link(class_q);
                ctrl.pc_src = PC_SRC_SEQ;
                state_d     = ST_FETCH;
            end

            ST_FAULT: begin
                state_d = ST_FAULT;
            end

            default: begin
                state_d = ST_FAULT;
                fault_d = FAULT_ILLEGAL;
            end
        endcase

        // The wait counter restarts whenever a new memory request phase begins.
        if ((state_d != state_q) && ((state_d == ST_FETCH) || (state_d == ST_MEM))) begin
            wait_d = '0;
        end
    end

    assign ctrl_out     = rst ? '0 : ctrl;
    assign mem_req      = ctrl_out.mem_req;
    assign mem_we       = ctrl_out.mem_we;
    assign mem_addr_sel = ctrl_out.mem_addr_sel;
    assign ir_we        = ctrl_out.ir_we;
    assign pc_we        = ctrl_out.pc_we;
    assign pc_src       = ctrl_out.pc_src;
    assign reg_we       = ctrl_out.reg_we;
    assign wb_sel       = ctrl_out.wb_sel;
    assign alu_a_sel    = ctrl_out.alu_a_sel;
    assign alu_b_sel    = ctrl_out.alu_b_sel;
    assign alu_op       = ctrl_out.alu_op;
    assign instret      = ctrl_out.instret;
    assign fault_code   = rst ? FAULT_NONE : fault_q;
    assign state_dbg    = rst ? 3'd0 : state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed scoreboard bench for multicycle_controller: stimulus queues per-cycle expected
// control vectors, a monitor compares them against the DUT on the falling edge.
module tb_multicycle_controller;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       reg_we;
    logic [1:0] wb_sel;
    logic       alu_a_sel;
    logic       alu_b_sel;
    logic [1:0] alu_op;
    logic       instret;
    logic [1:0] fault_code;
    logic [2:0] state_dbg;
  } obs_t;

  typedef struct {
    obs_t  exp;
    string name;
  } sb_t;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        branch_taken;
  logic        mem_ready;
  logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, reg_we;
  logic        alu_a_sel, alu_b_sel, instret;
  logic [1:0]  pc_src, wb_sel, alu_op, fault_code;
  logic [2:0]  state_dbg;

  sb_t sbq[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  bit  done     = 0;

  multicycle_controller #(.TIMEOUT_CYCLES(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr        (instr),
    .branch_taken (branch_taken),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .pc_src       (pc_src),
    .reg_we       (reg_we),
    .wb_sel       (wb_sel),
    .alu_a_sel    (alu_a_sel),
    .alu_b_sel    (alu_b_sel),
    .alu_op       (alu_op),
    .instret      (instret),
    .fault_code   (fault_code),
    .state_dbg    (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t st(input logic [2:0] s);
    obs_t o;
    o = '0;
    o.state_dbg = s;
    return o;
  endfunction

  // One clock cycle of stimulus: drive inputs, queue the expected outputs for this cycle.
  task automatic cyc(input string nm, input logic r, input logic rdy, input logic bt,
                     input obs_t e);
    sb_t item;
    rst          = r;
    mem_ready    = rdy;
    branch_taken = bt;
    item.exp     = e;
    item.name    = nm;
    sbq.push_back(item);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_decode(input string nm, input logic [31:0] ins);
    obs_t e;
    instr = ins;
    e = st(3'd0); e.mem_req = 1'b1; e.ir_we = 1'b1;
    cyc({nm, ".F"}, 1'b0, 1'b1, 1'b0, e);
    e = st(3'd1);
    cyc({nm, ".D"}, 1'b0, 1'b1, 1'b0, e);
  endtask

  task automatic fetch_wait(input string nm);
    obs_t e;
    e = st(3'd0); e.mem_req = 1'b1;
    cyc({nm, ".Fw"}, 1'b0, 1'b0, 1'b0, e);
  endtask

  task automatic reset_cycle(input string nm);
    cyc({nm, ".rst"}, 1'b1, 1'b1, 1'b0, st(3'd0));
  endtask

  // Monitor: compares every presented cycle against the head of the scoreboard.
  initial begin
    sb_t  item;
    obs_t act;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        item = sbq.pop_front();
        act = '{mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, reg_we, wb_sel,
                alu_a_sel, alu_b_sel, alu_op, instret, fault_code, state_dbg};
        n_checks++;
        if (act !== item.exp) begin
          n_fail++;
          $display("FAIL %s: got %05h expected %05h (state got %0d exp %0d)",
                   item.name, act, item.exp, act.state_dbg, item.exp.state_dbg);
        end
        n_checks++;
        if (state_dbg !== item.exp.state_dbg) begin
          n_fail++;
          $display("FAIL %s: state_dbg got %0d expected %0d",
                   item.name, state_dbg, item.exp.state_dbg);
        end
      end else if (done) begin
        if (n_checks < 12) begin
          n_fail++;
          $display("FAIL too few checks: %0d", n_checks);
        end
        if (n_fail != 0) begin
          $display("FAIL %0d mismatches", n_fail);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t e;
    rst = 1'b1; mem_ready = 1'b0; branch_taken = 1'b0; instr = 32'h0;
    @(posedge clk);
    #1;

    reset_cycle("init0");
    reset_cycle("init1");

    // addi x1,x0,5 with memory always ready
    fetch_decode("addi", 32'h00500093);
    e = st(3'd2); e.alu_b_sel = 1'b1; e.alu_op = 2'd2;
    cyc("addi.E", 1'b0, 1'b1, 1'b0, e);
    e = st(3'd4); e.reg_we = 1'b1; e.pc_we = 1'b1; e.instret = 1'b1;
    cyc("addi.W", 1'b0, 1'b1, 1'b0, e);

    // add x3,x1,x2: fetch ready arrives exactly when the wait count hits the limit
    for (int i = 0; i < 4; i++) fetch_wait("add");
    fetch_decode("add", 32'h002081B3);
    e = st(3'd2); e.alu_op = 2'd1;
    cyc("add.E", 1'b0, 1'b1, 1'b0, e);
    e = st(3'd4); e.reg_we = 1'b1; e.pc_we = 1'b1; e.instret = 1'b1;
    cyc("add.W", 1'b0, 1'b1, 1'b0, e);

    // lw x2,0(x0) with three data wait cycles
    fetch_decode("lw", 32'h00002103);
    e = st(3'd2); e.alu_b_sel = 1'b1;
    cyc("lw.E", 1'b0, 1'b1, 1'b0, e);
    e = st(3'd3); e.mem_req = 1'b1; e.mem_addr_sel = 1'b1;
    for (int i = 0; i < 3; i++) cyc("lw.Mw", 1'b0, 1'b0, 1'b0, e);
    cyc("lw.M", 1'b0, 1'b1, 1'b0, e);
    e = st(3'd4); e.reg_we = 1'b1; e.wb_sel = 2'd1; e.pc_we = 1'b1; e.instret = 1'b1;
    cyc("lw.W", 1'b0, 1'b1, 1'b0, e);

    // beq taken / not taken
    fetch_decode("beqT", 32'h00000463);
    e = st(3'd2); e.alu_op = 2'd3; e.pc_we = 1'b1; e.pc_src = 2'd1; e.instret = 1'b1;
    cyc("beqT.E", 1'b0, 1'b1, 1'b1, e);
    fetch_decode("beqN", 32'h00000463);
    e = st(3'd2); e.alu_op = 2'd3; e.pc_we = 1'b1; e.pc_src = 2'd0; e.instret = 1'b1;
    cyc("beqN.E", 1'b0, 1'b1, 1'b0, e);

    // jal x1,+16
    fetch_decode("jal", 32'h010000EF);
    e = st(3'd2); e.pc_we = 1'b1; e.pc_src = 2'd1;
    cyc("jal.E", 1'b0, 1'b1, 1'b0, e);
    e = st(3'd4); e.reg_we = 1'b1; e.wb_sel = 2'd2; e.instret = 1'b1;
    cyc("jal.W", 1'b0, 1'b1, 1'b0, e);

    // jalr x1,0(x1)
    fetch_decode("jalr", 32'h000080E7);
    e = st(3'd2); e.alu_b_sel = 1'b1; e.pc_we = 1'b1; e.pc_src = 2'd2;
    cyc("jalr.E", 1'b0, 1'b1, 1'b0, e);
    e = st(3'd4); e.reg_we = 1'b1; e.wb_sel = 2'd2; e.instret = 1'b1;
    cyc("jalr.W", 1'b0, 1'b1, 1'b0, e);

    // lui x1,0x12345
    fetch_decode("lui", 32'h123450B7);
    cyc("lui.E", 1'b0, 1'b1, 1'b0, st(3'd2));
    e = st(3'd4); e.reg_we = 1'b1; e.wb_sel = 2'd3; e.pc_we = 1'b1; e.instret = 1'b1;
    cyc("lui.W", 1'b0, 1'b1, 1'b0, e);

    // auipc x1,1
    fetch_decode("auipc", 32'h00001097);
    e = st(3'd2); e.alu_a_sel = 1'b1; e.alu_b_sel = 1'b1;
    cyc("auipc.E", 1'b0, 1'b1, 1'b0, e);
    e = st(3'd4); e.reg_we = 1'b1; e.pc_we = 1'b1; e.instret = 1'b1;
    cyc("auipc.W", 1'b0, 1'b1, 1'b0, e);

    // fence behaves as a NOP
    fetch_decode("fence", 32'h0000000F);
    e = st(3'd2); e.pc_we = 1'b1; e.instret = 1'b1;
    cyc("fence.E", 1'b0, 1'b1, 1'b0, e);

    // sw x2,4(x0) with one fetch wait cycle
    fetch_wait("sw");
    fetch_decode("sw", 32'h00202223);
    e = st(3'd2); e.alu_b_sel = 1'b1;
    cyc("sw.E", 1'b0, 1'b1, 1'b0, e);
    e = st(3'd3); e.mem_req = 1'b1; e.mem_we = 1'b1; e.mem_addr_sel = 1'b1;
    e.pc_we = 1'b1; e.instret = 1'b1;
    cyc("sw.M", 1'b0, 1'b1, 1'b0, e);

    // reset while a store is waiting in MEM abandons it
    fetch_decode("swrst", 32'h00202223);
    e = st(3'd2); e.alu_b_sel = 1'b1;
    cyc("swrst.E", 1'b0, 1'b1, 1'b0, e);
    e = st(3'd3); e.mem_req = 1'b1; e.mem_we = 1'b1; e.mem_addr_sel = 1'b1;
    cyc("swrst.Mw", 1'b0, 1'b0, 1'b0, e);
    reset_cycle("swrst");
    fetch_wait("swrst.after");
    fetch_decode("addi2", 32'h00500093);
    e = st(3'd2); e.alu_b_sel = 1'b1; e.alu_op = 2'd2;
    cyc("addi2.E", 1'b0, 1'b1, 1'b0, e);
    e = st(3'd4); e.reg_we = 1'b1; e.pc_we = 1'b1; e.instret = 1'b1;
    cyc("addi2.W", 1'b0, 1'b1, 1'b0, e);

    // illegal opcode 0x7F: sticky fault
    fetch_decode("ill", 32'h0000007F);
    e = st(3'd5); e.fault_code = 2'd1;
    cyc("ill.FLT0", 1'b0, 1'b1, 1'b0, e);
    cyc("ill.FLT1", 1'b0, 1'b0, 1'b1, e);
    cyc("ill.FLT2", 1'b0, 1'b1, 1'b0, e);
    reset_cycle("ill");

    // ecall
    fetch_decode("ecall", 32'h00000073);
    e = st(3'd5); e.fault_code = 2'd3;
    cyc("ecall.FLT0", 1'b0, 1'b1, 1'b0, e);
    cyc("ecall.FLT1", 1'b0, 1'b1, 1'b0, e);
    reset_cycle("ecall");

    // fetch timeout: five waiting FETCH cycles, then fault code 2
    for (int i = 0; i < 5; i++) fetch_wait("tmo");
    e = st(3'd5); e.fault_code = 2'd2;
    cyc("tmo.FLT0", 1'b0, 1'b0, 1'b0, e);
    cyc("tmo.FLT1", 1'b0, 1'b1, 1'b0, e);
    reset_cycle("tmo");
    fetch_decode("post", 32'h0000000F);
    e = st(3'd2); e.pc_we = 1'b1; e.instret = 1'b1;
    cyc("post.E", 1'b0, 1'b1, 1'b0, e);

    done = 1'b1;
  end

endmodule
